// File: rtl/rx_bank_arbiter_pkg.sv
// Shared constants and FIFO entry record for the RX bank arbiter.
package rx_bank_arbiter_pkg;

  localparam int unsigned LANE_CNT   = 4;
  localparam int unsigned LANE_W     = 2;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned MEM_ADDR_W = 18;

  // One buffered write: lane-local word address plus pixel data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  // Lane index 'step' positions after 'base', wrapping over the four lanes.
  function automatic logic [LANE_W-1:0] rr_next(input logic [LANE_W-1:0] base,
                                                input int unsigned       step);
    return base + LANE_W'(step);
  endfunction

endpackage

// File: rtl/rx_bank_arbiter_lane_fifo.sv
// Per-lane FIFO of {addr, data}; show-ahead read, occupancy counter saturates at DEPTH and 0.
module lane_fifo
  import rx_bank_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     Cclk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  fifo_entry_t              din,
  output fifo_entry_t              dout_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Status flags and qualified push/pop; a full FIFO still accepts when popped the same cycle.
  always_comb begin
    full_c  = (count == CNT_W'(DEPTH));
    empty_c = (count == '0);
    pop_ok  = pop && !empty_c;
    push_ok = push && (!full_c || pop_ok);
    dout_c  = mem[rd_ptr];
  end

  // Pointer and occupancy update.
  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Entry storage; contents need no reset since the counter gates visibility.
  always_ff @(posedge Cclk) begin
    if (rstn && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rx_bank_arbiter.sv
// Buffers four SPI receive lanes and round-robins them onto one shared memory write port.
module rx_bank_arbiter
  import rx_bank_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NLANE = LANE_CNT
) (
  input  logic                    Cclk,
  input  logic                    rstn,
  input  logic [NLANE-1:0]        req_valid,
  input  logic [NLANE*DATA_W-1:0] req_data,
  input  logic [NLANE*ADDR_W-1:0] req_addr,
  input  logic                    rd_slot,
  output logic                    mem_we,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [NLANE-1:0]        pend,
  output logic [NLANE-1:0]        ovf,
  input  logic                    ovf_clr
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fifo_entry_t       lane_dout_c  [NLANE];
  logic [CNT_W-1:0]  lane_count   [NLANE];
  logic [NLANE-1:0]  lane_full_c;
  logic [NLANE-1:0]  lane_empty_c;
  logic [NLANE-1:0]  pop_c;
  logic [NLANE-1:0]  ovf_set_c;
  logic              grant_c;
  logic [LANE_W-1:0] grant_lane_c;
  logic [LANE_W-1:0] last_grant;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    fifo_entry_t din;

    assign din = {req_addr[ADDR_W*i +: ADDR_W], req_data[DATA_W*i +: DATA_W]};

    lane_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .Cclk    (Cclk),
      .rstn    (rstn),
      .push    (req_valid[i]),
      .pop     (pop_c[i]),
      .din     (din),
      .dout_c  (lane_dout_c[i]),
      .full_c  (lane_full_c[i]),
      .empty_c (lane_empty_c[i]),
      .count   (lane_count[i])
    );
  end

  // Pending flags straight from occupancy.
  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      pend[i] = (lane_count[i] != '0);
    end
  end

  // Round-robin grant starting one past the last granted lane; display reads block the port.
  always_comb begin
    logic [LANE_W-1:0] idx;
    idx          = '0;
    grant_c      = 1'b0;
    grant_lane_c = last_grant;
    pop_c        = '0;
    if (!rd_slot) begin
      for (int unsigned k = 1; k <= NLANE; k++) begin
        idx = rr_next(last_grant, k);
        if (!grant_c && !lane_empty_c[idx]) begin
          grant_c      = 1'b1;
          grant_lane_c = idx;
        end
      end
    end
    if (grant_c) pop_c[grant_lane_c] = 1'b1;
  end

  // A word is lost when its FIFO is full and not draining this cycle.
  always_comb begin
    ovf_set_c = req_valid & lane_full_c & ~pop_c;
  end

  // Sticky overflow flags; a fresh overflow wins over a simultaneous clear.
  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{NLANE{ovf_clr}}) | ovf_set_c;
    end
  end

  // Registered memory write port and round-robin pointer.
  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last_grant <= LANE_W'(NLANE - 1);
    end else begin
      mem_we <= grant_c;
      if (grant_c) begin
        mem_addr   <= {grant_lane_c, lane_dout_c[grant_lane_c].addr};
        mem_wdata  <= lane_dout_c[grant_lane_c].data;
        last_grant <= grant_lane_c;
      end
    end
  end

endmodule

// File: tb/tb_rx_bank_arbiter.sv
// Self-checking bench: directed vector table, corner-case sequences, then random traffic vs a queue model.
module tb_rx_bank_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        Cclk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [47:0] req_data = '0;
  logic [63:0] req_addr = '0;
  logic        rd_slot = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [3:0]  pend;
  logic [3:0]  ovf;

  rx_bank_arbiter #(.DEPTH(DEPTH), .NLANE(4)) dut (
    .Cclk      (Cclk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .rd_slot   (rd_slot),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .pend      (pend),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 Cclk = ~Cclk;

  // Reference model state: one queue of {addr16, data12} per lane.
  logic [27:0] mq [4][$];
  int          m_last = 3;
  logic        m_we = 1'b0;
  logic [17:0] m_addr = '0;
  logic [11:0] m_wdata = '0;
  logic [3:0]  m_ovf = '0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_pend();
    logic [3:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[l] = (mq[l].size() != 0);
    return r;
  endfunction

  // One clock edge of the behavioural model, using the inputs currently applied.
  task automatic model_step();
    int          g;
    logic [27:0] e;
    logic [3:0]  nov;
    g = -1;
    if (!rstn) begin
      for (int l = 0; l < 4; l++) mq[l].delete();
      m_last  = 3;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_ovf   = '0;
    end else begin
      if (!rd_slot) begin
        for (int k = 1; k <= 4; k++) begin
          if (g < 0 && mq[(m_last + k) % 4].size() > 0) g = (m_last + k) % 4;
        end
      end
      if (g >= 0) begin
        e       = mq[g].pop_front();
        m_we    = 1'b1;
        m_addr  = 18'((g << 16) | int'(e[27:12]));
        m_wdata = e[11:0];
        m_last  = g;
      end else begin
        m_we = 1'b0;
      end
      nov = ovf_clr ? 4'h0 : m_ovf;
      for (int l = 0; l < 4; l++) begin
        if (req_valid[l]) begin
          if (mq[l].size() < int'(DEPTH)) mq[l].push_back({req_addr[16*l +: 16], req_data[12*l +: 12]});
          else nov[l] = 1'b1;
        end
      end
      m_ovf = nov;
    end
  endtask

  // Apply one cycle of inputs, advance DUT and model together, compare all outputs.
  task automatic cyc(input string tag, input logic r, input logic [3:0] v, input logic rd,
                     input logic clr, input logic [47:0] d, input logic [63:0] a);
    rstn      = r;
    req_valid = v;
    rd_slot   = rd;
    ovf_clr   = clr;
    req_data  = d;
    req_addr  = a;
    @(posedge Cclk);
    model_step();
    #1;
    chk({tag, ".mem_we"},    32'(mem_we),    32'(m_we));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(m_addr));
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(m_wdata));
    chk({tag, ".pend"},      32'(pend),      32'(m_pend()));
    chk({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
  endtask

  typedef struct packed {
    logic        rstn;
    logic [3:0]  v;
    logic        rd;
    logic        clr;
    logic [47:0] d;
    logic [63:0] a;
    logic        e_we;
    logic [17:0] e_addr;
    logic [11:0] e_wd;
    logic [3:0]  e_pend;
    logic [3:0]  e_ovf;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [47:0] d;
    logic [63:0] a;
    logic [47:0] d36;
    logic [63:0] a36;
    logic [47:0] d35;
    logic [63:0] a35;
    logic        ph;

    d36 = {12'h103, 12'h102, 12'h101, 12'h100};
    a36 = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    d35 = {12'h000, 12'hABC, 24'h0};
    a35 = {16'h0000, 16'h0010, 32'h0};

    // Reset, single lane-2 write, then four-lane burst after reset.
    tbl[0]  = '{1'b0, 4'hF, 1'b1, 1'b1, d36, a36, 1'b0, 18'h00000, 12'h000, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 4'h4, 1'b0, 1'b0, d35, a35, 1'b0, 18'h00000, 12'h000, 4'h4, 4'h0};
    tbl[2]  = '{1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0, 1'b1, 18'h20010, 12'hABC, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0, 1'b0, 18'h20010, 12'hABC, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0, 1'b0, 18'h00000, 12'h000, 4'h0, 4'h0};
    tbl[5]  = '{1'b1, 4'hF, 1'b0, 1'b0, d36, a36, 1'b0, 18'h00000, 12'h000, 4'hF, 4'h0};
    tbl[6]  = '{1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0, 1'b1, 18'h01000, 12'h100, 4'hE, 4'h0};
    tbl[7]  = '{1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0, 1'b1, 18'h11001, 12'h101, 4'hC, 4'h0};
    tbl[8]  = '{1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0, 1'b1, 18'h21002, 12'h102, 4'h8, 4'h0};
    tbl[9]  = '{1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0, 1'b1, 18'h31003, 12'h103, 4'h0, 4'h0};
    tbl[10] = '{1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0, 1'b0, 18'h31003, 12'h103, 4'h0, 4'h0};

    for (int i = 0; i < 11; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].rstn, tbl[i].v, tbl[i].rd, tbl[i].clr, tbl[i].d, tbl[i].a);
      chk($sformatf("vec%0d.tbl_we", i),   32'(mem_we),    32'(tbl[i].e_we));
      chk($sformatf("vec%0d.tbl_addr", i), 32'(mem_addr),  32'(tbl[i].e_addr));
      chk($sformatf("vec%0d.tbl_wd", i),   32'(mem_wdata), 32'(tbl[i].e_wd));
      chk($sformatf("vec%0d.tbl_pend", i), 32'(pend),      32'(tbl[i].e_pend));
      chk($sformatf("vec%0d.tbl_ovf", i),  32'(ovf),       32'(tbl[i].e_ovf));
    end

    // rd_slot blocks lanes 0 and 1 for five cycles, then lane 0 then lane 1.
    cyc("rd_push", 1'b1, 4'h3, 1'b0, 1'b0, {24'h0, 12'h222, 12'h111}, {32'h0, 16'h0200, 16'h0100});
    chk("rd_push.pend", 32'(pend), 32'h3);
    for (int i = 0; i < 5; i++) begin
      cyc("rd_hold", 1'b1, 4'h0, 1'b1, 1'b0, 48'h0, 64'h0);
      chk($sformatf("rd_hold%0d.we", i), 32'(mem_we), 32'h0);
    end
    cyc("rd_w0", 1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0);
    chk("rd_w0.we", 32'(mem_we), 32'h1);
    chk("rd_w0.addr", 32'(mem_addr), 32'h00100);
    chk("rd_w0.wd", 32'(mem_wdata), 32'h111);
    cyc("rd_w1", 1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0);
    chk("rd_w1.we", 32'(mem_we), 32'h1);
    chk("rd_w1.addr", 32'(mem_addr), 32'h10200);
    chk("rd_w1.wd", 32'(mem_wdata), 32'h222);
    cyc("rd_idle", 1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0);
    chk("rd_idle.we", 32'(mem_we), 32'h0);

    // Lane 3 overflow: five requests into a four-deep FIFO, then four ordered writes.
    for (int k = 0; k < 5; k++) begin
      d = '0; a = '0;
      d[47:36] = 12'(12'h300 + k);
      a[63:48] = 16'(16'h3000 + k);
      cyc("ov3_fill", 1'b1, 4'h8, 1'b1, 1'b0, d, a);
      chk($sformatf("ov3_fill%0d.ovf", k), 32'(ovf), (k == 4) ? 32'h8 : 32'h0);
    end
    chk("ov3.pend", 32'(pend), 32'h8);
    for (int k = 0; k < 4; k++) begin
      cyc("ov3_drain", 1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0);
      chk($sformatf("ov3_drain%0d.we", k), 32'(mem_we), 32'h1);
      chk($sformatf("ov3_drain%0d.addr", k), 32'(mem_addr), 32'(18'h33000 + k));
      chk($sformatf("ov3_drain%0d.wd", k), 32'(mem_wdata), 32'(12'h300 + k));
    end
    cyc("ov3_end", 1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0);
    chk("ov3_end.we", 32'(mem_we), 32'h0);
    chk("ov3_end.pend", 32'(pend), 32'h0);

    // Clear coinciding with a new lane 1 overflow keeps that bit; clear alone drops it.
    for (int k = 0; k < 4; k++) begin
      d = '0; a = '0;
      d[23:12] = 12'(12'h500 + k);
      a[31:16] = 16'(16'h5000 + k);
      cyc("ov1_fill", 1'b1, 4'h2, 1'b1, 1'b0, d, a);
    end
    cyc("ov1_set", 1'b1, 4'h2, 1'b1, 1'b0, 48'h0, 64'h0);
    chk("ov1_set.ovf", 32'(ovf), 32'hA);
    cyc("ov1_clr_hit", 1'b1, 4'h2, 1'b1, 1'b1, 48'h0, 64'h0);
    chk("ov1_clr_hit.ovf", 32'(ovf), 32'h2);
    cyc("ov1_clr", 1'b1, 4'h0, 1'b1, 1'b1, 48'h0, 64'h0);
    chk("ov1_clr.ovf", 32'(ovf), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc("ov1_drain", 1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0);
      chk($sformatf("ov1_drain%0d.addr", k), 32'(mem_addr), 32'(18'h15000 + k));
    end

    // Reset with three entries pending and a grant otherwise due; lane 0 wins afterwards.
    cyc("rst_fill", 1'b1, 4'h7, 1'b1, 1'b0, {12'h0, 12'h333, 12'h222, 12'h111}, 64'h0);
    chk("rst_fill.pend", 32'(pend), 32'h7);
    cyc("rst", 1'b0, 4'hF, 1'b0, 1'b1, 48'hFFF_FFF_FFF_FFF, 64'h0);
    chk("rst.pend", 32'(pend), 32'h0);
    chk("rst.we", 32'(mem_we), 32'h0);
    chk("rst.ovf", 32'(ovf), 32'h0);
    cyc("rst_push", 1'b1, 4'h9, 1'b0, 1'b0, {12'h999, 24'h0, 12'h777}, {16'h0999, 32'h0, 16'h0777});
    chk("rst_push.we", 32'(mem_we), 32'h0);
    cyc("rst_g0", 1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0);
    chk("rst_g0.addr", 32'(mem_addr), 32'h00777);
    chk("rst_g0.wd", 32'(mem_wdata), 32'h777);
    cyc("rst_g1", 1'b1, 4'h0, 1'b0, 1'b0, 48'h0, 64'h0);
    chk("rst_g1.addr", 32'(mem_addr), 32'h30999);

    // Random traffic, alternating between read-heavy and write-heavy phases.
    ph = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) ph = ~ph;
      cyc("rand",
          ($urandom_range(0, 99) != 0),
          4'($urandom()),
          ph ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) == 0),
          48'({$urandom(), $urandom()}),
          {$urandom(), $urandom()});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
